// File: rtl/matrix_entry_buffer.sv
// rtl/matrix_entry_buffer.sv - N x N nibble matrix entry buffer with IDLE/ENTER/HOLD hand-off
// Optional MATRIX_ENTRY_AUTO_ADVANCE_EN: internal row-major write cursor replaces Row/Col addressing.
module matrix_entry_buffer (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [2:0]   Row,
  input  logic [2:0]   Col,
  input  logic [3:0]   Data,
  input  logic [3:0]   Dim,
  input  logic         Enter,
  input  logic         Start,
  input  logic         Clear,
  input  logic         Ack,
  output logic [255:0] Input_arr_flat,
  output logic         Valid,
  output logic [5:0]   Index,
  output logic [3:0]   Cur_data,
  output logic [6:0]   Filled,
  output logic         Err,
  output logic         q_Idle,
  output logic         q_Enter,
  output logic         q_Hold
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [255:0]   vals_q, vals_d;
  logic [63:0]    wr_q, wr_d;
  logic [3:0]     dim_q, dim_d;
  logic           err_q, err_d;
  logic [63:0]    win;
  logic [5:0]     addr;
  logic           in_range;
  logic           dim_ok;
  logic           wr_reject;
  logic           start_ok;
  logic           start_reject;
  logic [6:0]     filled_post;
  logic [6:0]     dim_sq;

  function automatic logic [6:0] popcnt(input logic [63:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) s = s + {6'd0, v[i]};
    return s;
  endfunction

`ifdef MATRIX_ENTRY_AUTO_ADVANCE_EN
  logic [5:0] cursor_q, cursor_d, cursor_adv;
  assign addr = cursor_q;

  // Row-major step inside the latched N x N window, wrapping to (0,0).
  always_comb begin
    cursor_adv = cursor_q;
    if (({1'b0, cursor_q[2:0]} + 4'd1) >= dim_q) begin
      cursor_adv[2:0] = 3'd0;
      if (({1'b0, cursor_q[5:3]} + 4'd1) >= dim_q) cursor_adv[5:3] = 3'd0;
      else cursor_adv[5:3] = cursor_q[5:3] + 3'd1;
    end else begin
      cursor_adv[2:0] = cursor_q[2:0] + 3'd1;
    end
  end
`else
  assign addr = {Row, Col};
`endif

  assign dim_ok   = (Dim != 4'd0) && (Dim <= 4'd8);
  assign in_range = ({1'b0, addr[5:3]} < dim_q) && ({1'b0, addr[2:0]} < dim_q);
  assign dim_sq   = 7'(dim_q) * 7'(dim_q);

  always_comb begin
    win = '0;
    for (int i = 0; i < 64; i++) begin
      win[i] = ({1'b0, 3'(i / 8)} < dim_q) && ({1'b0, 3'(i % 8)} < dim_q);
    end
  end

  // Storage update; Clear outranks Enter and HOLD freezes the contents.
  always_comb begin
    vals_d    = vals_q;
    wr_d      = wr_q;
    wr_reject = 1'b0;
`ifdef MATRIX_ENTRY_AUTO_ADVANCE_EN
    cursor_d  = cursor_q;
    if (state_q == S_IDLE && Start && dim_ok) cursor_d = 6'd0;
`endif
    if (state_q != S_HOLD && Clear) begin
      vals_d = '0;
      wr_d   = '0;
`ifdef MATRIX_ENTRY_AUTO_ADVANCE_EN
      cursor_d = 6'd0;
`endif
    end else if (state_q == S_ENTER && Enter) begin
      if (in_range) begin
        vals_d[{addr, 2'b00} +: 4] = Data;
        wr_d[addr]                 = 1'b1;
`ifdef MATRIX_ENTRY_AUTO_ADVANCE_EN
        cursor_d = cursor_adv;
`endif
      end else begin
        wr_reject = 1'b1;
      end
    end
  end

  // The hand-off check sees this cycle's write, so it uses the post-update bits.
  assign filled_post = popcnt(wr_d & win);

  always_comb begin
    state_d      = state_q;
    dim_d        = dim_q;
    start_ok     = 1'b0;
    start_reject = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (dim_ok) begin
            state_d  = S_ENTER;
            dim_d    = Dim;
            start_ok = 1'b1;
          end else begin
            start_reject = 1'b1;
          end
        end
      end
      S_ENTER: begin
        if (Start) begin
          if (filled_post == dim_sq) begin
            state_d  = S_HOLD;
            start_ok = 1'b1;
          end else begin
            start_reject = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (Ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = (err_q & ~start_ok) | wr_reject | start_reject;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      vals_q   <= '0;
      wr_q     <= '0;
      dim_q    <= '0;
      err_q    <= 1'b0;
`ifdef MATRIX_ENTRY_AUTO_ADVANCE_EN
      cursor_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vals_q   <= vals_d;
      wr_q     <= wr_d;
      dim_q    <= dim_d;
      err_q    <= err_d;
`ifdef MATRIX_ENTRY_AUTO_ADVANCE_EN
      cursor_q <= cursor_d;
`endif
    end
  end

  assign Input_arr_flat = vals_q;
  assign Valid          = (state_q == S_HOLD);
  assign Index          = addr;
  assign Cur_data       = vals_q[{addr, 2'b00} +: 4];
  assign Filled         = popcnt(wr_q & win);
  assign Err            = err_q;
  assign q_Idle         = (state_q == S_IDLE);
  assign q_Enter        = (state_q == S_ENTER);
  assign q_Hold         = (state_q == S_HOLD);

endmodule

// File: doc/matrix_entry_buffer.md
MATRIX_ENTRY_BUFFER -- requirements
Module: matrix_entry_buffer

Interface
REQ-001 SHALL have port Clk, input, 1, system clock (divided sys_clk); all state on rising edge.
REQ-002 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Row, input, 3, target row of entry.
REQ-004 SHALL have port Col, input, 3, target column of entry.
REQ-005 SHALL have port Data, input, 4, entry value.
REQ-006 SHALL have port Dim, input, 4, matrix order N; legal range 1..8.
REQ-007 SHALL have port Enter, input, 1, single-cycle pulse that writes Data.
REQ-008 SHALL have port Start, input, 1, single-cycle pulse that opens entry or requests hand-off.
REQ-009 SHALL have port Clear, input, 1, single-cycle pulse that erases all entries.
REQ-010 SHALL have port Ack, input, 1, consumer acceptance of the presented matrix.
REQ-011 SHALL have port Input_arr_flat, output, 256, packed matrix; entry i=8*row+col occupies bits [4i+3:4i].
REQ-012 SHALL have port Valid, output, 1, Input_arr_flat is stable and offered.
REQ-013 SHALL have port Index, output, 6, current cursor index.
REQ-014 SHALL have port Cur_data, output, 4, stored value at Index.
REQ-015 SHALL have port Filled, output, 7, count of written entries inside the N x N window.
REQ-016 SHALL have port Err, output, 1, sticky flag for a rejected Enter or Start.
REQ-017 SHALL have ports q_Idle, q_Enter, q_Hold, each output, 1, one-hot state indicators.

Function
REQ-018 SHALL implement states IDLE, ENTER and HOLD, with exactly one q_* output high.
REQ-019 IDLE SHALL go to ENTER on Start when Dim is in 1..8; a Start with Dim of 0 or above 8 SHALL set Err and keep the state at IDLE.
REQ-020 In ENTER, Enter SHALL write Data into entry Index and set that entry's written bit on the next edge; in-range writes SHALL update only the targeted nibble of Input_arr_flat.
REQ-021 An Enter that targets Row>=N or Col>=N SHALL be ignored and SHALL set Err.
REQ-022 Rewriting an entry that is already written SHALL overwrite the value and SHALL leave Filled unchanged.
REQ-023 Filled SHALL equal the popcount of written bits with row<N and col<N, recomputed every cycle.
REQ-024 In ENTER, Start with Filled=N*N SHALL move to HOLD and raise Valid on the next edge; Start with Filled<N*N SHALL set Err and keep the state at ENTER.
REQ-025 In HOLD, Valid SHALL stay 1, Input_arr_flat SHALL stay frozen, and Enter and Clear SHALL be ignored.
REQ-026 HOLD with Ack=1 SHALL go to IDLE, with Valid dropping on the same edge; entry contents SHALL be retained.
REQ-027 Clear in IDLE or ENTER SHALL zero all values and written bits in one cycle; the state SHALL be unchanged.
REQ-028 If Enter and Clear arrive in the same cycle, Clear SHALL win.
REQ-029 If Enter and Start arrive in the same cycle, the write SHALL complete first and the Start check SHALL use the post-write Filled.
REQ-030 Err SHALL clear only on the next accepted Start, or on reset.
REQ-031 Index SHALL equal 8*Row+Col combinationally; Cur_data SHALL be the stored nibble at Index with zero latency.

Reset
REQ-032 Reset_n low SHALL asynchronously force: state IDLE (q_Idle=1, q_Enter=0, q_Hold=0), all values and written bits 0, Input_arr_flat=0, Valid=0, Err=0, Filled=0, cursor 0.
REQ-033 Reset asserted during HOLD SHALL drop Valid immediately, without waiting for a clock edge.
REQ-034 Release of Reset_n SHALL take effect on the first rising Clk edge after deassertion.

Configuration
REQ-035 The macro MATRIX_ENTRY_AUTO_ADVANCE_EN SHALL select how the write address is formed.
REQ-036 When MATRIX_ENTRY_AUTO_ADVANCE_EN is defined: an internal 6-bit cursor SHALL supply Index and Row/Col SHALL be ignored; each accepted Enter SHALL advance the cursor row-major within N x N, so col N-1 goes to col 0 of the next row and (N-1,N-1) wraps to (0,0); entering ENTER and Clear SHALL reset the cursor to 0.
REQ-037 When MATRIX_ENTRY_AUTO_ADVANCE_EN is not defined: Index SHALL be driven from Row/Col as in REQ-031, and no cursor logic SHALL exist.

Verification
REQ-038 Dim=2, Start, then Enter (0,0)=3, (0,1)=1, (1,0)=4, (1,1)=2, then Start -> Valid=1, bits[3:0]=3, [7:4]=1, [35:32]=4, [39:36]=2, Filled=4.
REQ-039 Dim=3 with 8 entries written, then Start -> Err=1, state stays ENTER, Valid=0.
REQ-040 Dim=2, Enter at (2,0) -> Err=1, Filled unchanged, Input_arr_flat unchanged.
REQ-041 In HOLD, pulse Enter and Clear with Ack held low for 10 cycles -> Input_arr_flat frozen and Valid=1; then Ack=1 -> IDLE next edge with Valid=0.
REQ-042 Enter and Clear in the same cycle -> all entries 0 and Filled=0; Reset_n low mid-HOLD -> Valid=0 with no clock edge.
REQ-043 AUTO_ADVANCE build, Dim=3, nine Enters of values 1..9 -> entries 0,1,2,8,9,10,16,17,18 hold 1..9 and the cursor wraps to 0.
